// File: rtl/calc_port_engine.sv
// calc_port_engine: single-port calculator responder.
// A command and operand1 arrive in one cycle, operand2 in the next. The result
// (add, subtract, shift-left, shift-right) is returned as a one-cycle response
// LATENCY cycles after the operand2 cycle. Commands arriving while busy are dropped.
// Optional feature: define CALC_ERR_CNT_EN to enable the saturating error counter
// on err_count. When it is not defined, err_count is tied to zero.
module calc_port_engine #(
    parameter int unsigned LATENCY = 3,   // legal range 1..15
    parameter int unsigned DATA_W  = 32
) (
    input  logic              c_clk,
    input  logic              reset,        // asynchronous, active-low
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_WAIT, ST_RESP} state_e;
    typedef enum logic [1:0] {RESP_NONE = 2'd0, RESP_OK = 2'd1, RESP_ERR = 2'd2} resp_e;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    // The WAIT state lasts LATENCY-1 cycles. It leaves for RESP when the counter reads 1.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q;
    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] op1_q;
    resp_e             hold_resp_q;
    logic [DATA_W-1:0] hold_data_q;
    logic [3:0]        cnt_q;
    resp_e             out_resp_q;
    logic [DATA_W-1:0] out_data_q;
    logic              busy_q;

    resp_e             res_resp_d;
    logic [DATA_W-1:0] res_data_d;
    logic [DATA_W:0]   sum_d;
    logic [4:0]        shamt_d;

    // Compute the result from the latched command/op1 and operand2 on the bus.
    always_comb begin
        // NOTE: every output of this block gets a default first, so that no path leaves one unassigned and infers a latch.
        res_resp_d = RESP_ERR;
        res_data_d = '0;
        sum_d      = {1'b0, op1_q} + {1'b0, req_data_in};
        shamt_d    = req_data_in[4:0];
        case (cmd_q)
            CMD_ADD: begin
                if (!sum_d[DATA_W]) begin
                    res_resp_d = RESP_OK;
                    res_data_d = sum_d[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (req_data_in <= op1_q) begin
                    res_resp_d = RESP_OK;
                    res_data_d = op1_q - req_data_in;
                end
            end
            CMD_SHL: begin
                res_resp_d = RESP_OK;
                res_data_d = op1_q << shamt_d;
            end
            CMD_SHR: begin
                res_resp_d = RESP_OK;
                res_data_d = op1_q >> shamt_d;
            end
            default: ;  // invalid command: error response, data 0
        endcase
    end

    // Request FSM with registered response and busy outputs.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NOP;
            op1_q       <= '0;
            hold_resp_q <= RESP_NONE;
            hold_data_q <= '0;
            cnt_q       <= '0;
            out_resp_q  <= RESP_NONE;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments. Every register then sees the values from before the edge, whatever the statement order.
            case (state_q)
                ST_IDLE: begin
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_q   <= req_cmd_in;
                        op1_q   <= req_data_in;
                        busy_q  <= 1'b1;
                        state_q <= ST_OP2;
                    end
                end
                ST_OP2: begin
                    hold_resp_q <= res_resp_d;
                    hold_data_q <= res_data_d;
                    cnt_q       <= CNT_INIT;
                    if (LATENCY == 1) begin
                        out_resp_q <= res_resp_d;
                        out_data_q <= res_data_d;
                        state_q    <= ST_RESP;
                    end else begin
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        out_resp_q <= hold_resp_q;
                        out_data_q <= hold_data_q;
                        state_q    <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    out_resp_q <= RESP_NONE;
                    out_data_q <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_resp = out_resp_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;

`ifdef CALC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Count error responses and saturate at 255. Only reset clears the count.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (state_q == ST_RESP && out_resp_q == RESP_ERR && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_calc_port_engine.sv
// Testbench for calc_port_engine.
// The main instance uses LATENCY=3. A second instance uses LATENCY=1 for the
// shortest-latency path. Table-driven vectors drive the main instance, and
// hand-written sequences cover busy-drop, no-op and reset-abort.
module tb_calc_port_engine;

    localparam int LAT = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  cmd   = '0;
    logic [31:0] data  = '0;
    logic [1:0]  resp;
    logic [31:0] odata;
    logic        busy;
    logic [7:0]  errc;

    logic [3:0]  cmd1  = '0;
    logic [31:0] data1 = '0;
    logic [1:0]  resp1;
    logic [31:0] odata1;
    logic        busy1;
    logic [7:0]  errc1;

    int checks  = 0;
    int errors  = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    calc_port_engine #(.LATENCY(LAT), .DATA_W(32)) dut (
        .c_clk(clk), .reset(rst_n), .req_cmd_in(cmd), .req_data_in(data),
        .out_resp(resp), .out_data(odata), .busy(busy), .err_count(errc)
    );

    calc_port_engine #(.LATENCY(1), .DATA_W(32)) dut1 (
        .c_clk(clk), .reset(rst_n), .req_cmd_in(cmd1), .req_data_in(data1),
        .out_resp(resp1), .out_data(odata1), .busy(busy1), .err_count(errc1)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_errc();
`ifdef CALC_ERR_CNT_EN
        return 32'(exp_err);
`else
        return 32'd0;
`endif
    endfunction

    // The command cycle, followed by the operand2 cycle. The task returns just before the operand2 edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] op1, input logic [31:0] op2);
        @(negedge clk);
        cmd  = c;
        data = op1;
        @(negedge clk);
        cmd  = 4'd0;
        data = op2;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        issue(v.cmd, v.op1, v.op2);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            data = '0;
            if (k < LAT) begin
                check($sformatf("%s pre resp c%0d", tag, k), 32'(resp), 32'd0);
                check($sformatf("%s pre busy c%0d", tag, k), 32'(busy), 32'd1);
            end else begin
                check($sformatf("%s resp", tag), 32'(resp), 32'(v.resp));
                check($sformatf("%s data", tag), odata, v.data);
            end
        end
        if (v.resp == 2'd2 && exp_err < 255) exp_err++;
        @(negedge clk);
        check($sformatf("%s post resp", tag), 32'(resp), 32'd0);
        check($sformatf("%s post data", tag), odata, 32'd0);
        check($sformatf("%s post busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s err_count", tag), 32'(errc), exp_errc());
    endtask

    task automatic watch_quiet(input int n, input string tag);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (resp != 2'd0 || busy != 1'b0) bad++;
        end
        check($sformatf("%s quiet cycles", tag), 32'(bad), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'h0000_0005, 32'h0000_0001, 2'd1, 32'h0000_0006};
        vecs[1]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[2]  = '{4'd2, 32'h0000_0003, 32'h0000_0004, 2'd2, 32'h0000_0000};
        vecs[3]  = '{4'd2, 32'h0000_0004, 32'h0000_0004, 2'd1, 32'h0000_0000};
        vecs[4]  = '{4'd5, 32'h0000_0001, 32'h0000_002F, 2'd1, 32'h0000_8000};
        vecs[5]  = '{4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'h0000_0001};
        vecs[6]  = '{4'd3, 32'h0000_0007, 32'h0000_0007, 2'd2, 32'h0000_0000};
        vecs[7]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
        vecs[8]  = '{4'd2, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000};
        vecs[9]  = '{4'd2, 32'h0000_0009, 32'h0000_0003, 2'd1, 32'h0000_0006};
        vecs[10] = '{4'd7, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[11] = '{4'd5, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
        vecs[12] = '{4'd6, 32'h0000_00F0, 32'hFFFF_FFE4, 2'd1, 32'h0000_000F};
        vecs[13] = '{4'd15, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[14] = '{4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF};

        // Reset is held low for 7 cycles.
        #1 rst_n = 1'b0;
        repeat (7) @(negedge clk);
        check("reset resp", 32'(resp), 32'd0);
        check("reset data", odata, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err_count", 32'(errc), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // A no-op in IDLE never produces a response or raises busy.
        @(negedge clk);
        cmd  = 4'd0;
        data = 32'h123;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("nop busy c%0d", k), 32'(busy), 32'd0);
            check($sformatf("nop resp c%0d", k), 32'(resp), 32'd0);
        end
        data = '0;

        // A command issued during WAIT is dropped.
        issue(4'd1, 32'd2, 32'd2);
        @(negedge clk);
        cmd  = 4'd1;
        data = 32'd9;
        check("drop busy", 32'(busy), 32'd1);
        @(negedge clk);
        cmd  = 4'd0;
        data = '0;
        check("drop pre resp", 32'(resp), 32'd0);
        @(negedge clk);
        check("drop resp", 32'(resp), 32'd1);
        check("drop data", odata, 32'd4);
        watch_quiet(6, "drop");
        run_vec('{4'd1, 32'd3, 32'd4, 2'd1, 32'd7}, "after_drop");

        // Reset during WAIT aborts the request.
        issue(4'd1, 32'd1, 32'd1);
        @(negedge clk);
        data = '0;
        #2 rst_n = 1'b0;
        #1;
        exp_err = 0;
        check("rst_wait busy", 32'(busy), 32'd0);
        check("rst_wait resp", 32'(resp), 32'd0);
        check("rst_wait data", odata, 32'd0);
        check("rst_wait err_count", 32'(errc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(6, "rst_wait");

        // Reset asserted inside the response cycle clears the outputs at once.
        issue(4'd2, 32'd3, 32'd4);
        repeat (LAT) @(negedge clk);
        data = '0;
        check("rst_resp before", 32'(resp), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp resp", 32'(resp), 32'd0);
        check("rst_resp busy", 32'(busy), 32'd0);
        check("rst_resp err_count", 32'(errc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(4, "rst_resp");

        // LATENCY = 1 instance.
        @(negedge clk);
        cmd1  = 4'd1;
        data1 = 32'd1;
        @(negedge clk);
        cmd1  = 4'd0;
        data1 = 32'd1;
        check("lat1 op2 resp", 32'(resp1), 32'd0);
        check("lat1 op2 busy", 32'(busy1), 32'd1);
        @(negedge clk);
        data1 = '0;
        check("lat1 resp", 32'(resp1), 32'd1);
        check("lat1 data", odata1, 32'd2);
        @(negedge clk);
        check("lat1 post resp", 32'(resp1), 32'd0);
        check("lat1 post busy", 32'(busy1), 32'd0);
        cmd1  = 4'd1;
        data1 = 32'hFFFF_FFFF;
        @(negedge clk);
        cmd1  = 4'd0;
        data1 = 32'd1;
        @(negedge clk);
        data1 = '0;
        check("lat1 ovf resp", 32'(resp1), 32'd2);
        check("lat1 ovf data", odata1, 32'd0);
        @(negedge clk);
        check("lat1 ovf post resp", 32'(resp1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_port_engine.md
Name: calc_port_engine

Overview:
Single-port calculator responder: the DUT-side end of the request/response protocol the calculator benches drive.
- Accepts a command with operand1 in one cycle and operand2 in the next cycle.
- Computes add, subtract, shift-left or shift-right, and returns a one-cycle response (resp code plus data) after a fixed latency.
- Four instances plus an arbiter form the next-generation calculator top; the block also serves as a golden responder for bench bring-up.

Parameters:
LATENCY, 3, cycles from the operand2 cycle to the response cycle; legal range 1..15.
DATA_W, 32, operand and result width.

Ports:
c_clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_cmd_in  input  4  command; sampled only in IDLE.
req_data_in  input  DATA_W  operand1 in the command cycle, operand2 in the following cycle.
out_resp  output  2  0 = none, 1 = success, 2 = overflow/underflow/invalid command, 3 = never driven.
out_data  output  DATA_W  result; nonzero only in the response cycle with out_resp = 1.
busy  output  1  high while a request is in flight (OP2, WAIT and RESP states).
err_count  output  8  error counter (see Optional Feature).

Behaviour:
- Reset asserted (reset = 0): asynchronously force state IDLE; out_resp = 0, out_data = 0, busy = 0, err_count = 0, latency counter = 0.
- Reset mid-operation aborts the request; no response is ever produced for it.
- Commands: 0 no-op; 1 add (op1 + op2); 2 subtract (op1 - op2); 5 shift left (op1 << op2[4:0]); 6 shift right logical (op1 >> op2[4:0]). All other codes are invalid.
- FSM states: IDLE, OP2, WAIT, RESP.
- IDLE: if req_cmd_in != 0, latch cmd and op1 -> OP2. If req_cmd_in = 0, stay in IDLE with outputs 0.
- OP2: latch op2 unconditionally; req_cmd_in is ignored. Compute the result into the holding registers; load counter = LATENCY-1. Go to RESP if LATENCY = 1, else WAIT.
- WAIT: decrement counter; go to RESP when the counter reaches 1.
- RESP: out_resp and out_data are registered values, valid for exactly one cycle, so the response appears LATENCY cycles after the operand2 cycle. Next state IDLE; out_resp and out_data return to 0.
- Inputs in the RESP cycle are ignored. A new command is accepted earliest in the cycle after RESP, i.e. when busy = 0.
- Add: 33-bit sum. Carry out -> resp 2, data 0; otherwise resp 1 with the 32-bit sum.
- Subtract: op2 > op1 (unsigned) -> resp 2, data 0. op1 = op2 -> resp 1, data 0.
- Shifts: op2 bits [31:5] are ignored and never raise an error; shift amount 0 returns op1. Shifts always return resp 1.
- Invalid command: the operand2 cycle is still consumed; response is resp 2, data 0 after LATENCY.
- Commands arriving while busy = 1 are dropped silently. No queuing.
- Boundaries:
  - 0xFFFFFFFF + 0 -> resp 1.
  - 0xFFFFFFFF + 1 -> resp 2.
  - 0 - 0 -> resp 1, data 0.
  - 0x80000000 >> 31 -> resp 1, data 1.

Optional Feature:
Macro: CALC_ERR_CNT_EN.
- Defined: err_count increments by 1 in every RESP cycle whose out_resp = 2. It saturates at 255 and is cleared only by reset.
- Undefined: no counter logic; err_count is tied to 0.

Test Plan:
1. Reset held low 7 cycles, then released; cmd 1, op1 0x5, op2 0x1 -> out_resp 1, out_data 0x6 exactly 3 cycles after the op2 cycle; outputs 0 in the cycle before and the cycle after.
2. Overflow and underflow:
   - cmd 1, op1 0xFFFFFFFF, op2 0x1 -> resp 2, data 0.
   - cmd 2, op1 0x3, op2 0x4 -> resp 2, data 0.
   - cmd 2, op1 0x4, op2 0x4 -> resp 1, data 0.
   - With CALC_ERR_CNT_EN defined, err_count = 2 after these three requests.
3. Shifts:
   - cmd 5, op1 0x1, op2 0x2F -> resp 1, data 0x8000 (amount 15).
   - cmd 6, op1 0x80000000, op2 31 -> resp 1, data 0x1.
4. Invalid cmd 3, op1 0x7, op2 0x7 -> resp 2, data 0 after LATENCY. Cmd 0 in IDLE -> no response, busy stays 0.
5. Busy drop: cmd 1 (op1 2, op2 2) followed by cmd 1 (op1 9) in the WAIT cycle -> only resp 1, data 4 appears. A command issued after busy falls -> normal response.
6. Reset driven low during WAIT -> outputs 0 immediately and no response appears. LATENCY = 1 build: cmd 1, op1 1, op2 1 -> resp 1, data 2 in the cycle after the op2 cycle.
